// File: rtl/layer_vector_feeder_if.sv
// rtl/layer_vector_feeder_if.sv - activation word stream into the layer vector feeder
interface layer_vector_feeder_if #(
    parameter int DW = 32
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;

    modport master (output in_data, output in_valid, output in_last, input in_ready);
    modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/layer_vector_feeder.sv
// rtl/layer_vector_feeder.sv - assembles activation words into a vector, launches it, tracks bank latency
module layer_vector_feeder #(
    parameter int NUM_IN = 15,
    parameter int DW     = 32,
    parameter int LAT    = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    layer_vector_feeder_if.slave   s,
    input  logic                   hold,
    output logic [NUM_IN*DW-1:0]   a_bus,
    output logic                   vec_valid,
    output logic                   res_valid,
    output logic                   misalign,
    output logic [5:0]             count
);
    typedef enum logic {FILL, FULL} state_t;

    localparam logic [6:0] K_LAST = 7'(NUM_IN - 1);

    state_t                state;
    logic [6:0]            k;
    logic [DW-1:0]         shadow [NUM_IN];
    logic [LAT-1:0]        lat_sr;
    logic [NUM_IN*DW-1:0]  launch_vec;

    assign s.in_ready = (state == FILL);
    assign res_valid  = lat_sr[LAT-1];
    assign count      = (k > 7'd63) ? 6'd63 : k[5:0];

    // In FILL a launch can only be the fast path, so the final word comes straight from the stream.
    always_comb begin
        launch_vec = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            launch_vec[i*DW +: DW] = shadow[i];
        end
        if (state == FILL) begin
            launch_vec[(NUM_IN-1)*DW +: DW] = s.in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FILL;
            k         <= '0;
            a_bus     <= '0;
            vec_valid <= 1'b0;
            misalign  <= 1'b0;
            lat_sr    <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            vec_valid <= 1'b0;
            lat_sr    <= (lat_sr << 1) | LAT'(vec_valid);
            case (state)
                FILL: begin
                    if (s.in_valid) begin
                        if (k == K_LAST) begin
                            shadow[NUM_IN-1] <= s.in_data;
                            if (!s.in_last) begin
                                misalign <= 1'b1;
                            end
                            if (hold) begin
                                state <= FULL;
                                k     <= 7'(NUM_IN);
                            end else begin
                                a_bus     <= launch_vec;
                                vec_valid <= 1'b1;
                                k         <= '0;
                            end
                        end else if (s.in_last) begin
                            // Early in_last: drop the word and the partial vector.
                            misalign <= 1'b1;
                            k        <= '0;
                        end else begin
                            for (int i = 0; i < NUM_IN - 1; i++) begin
                                if (k == 7'(i)) begin
                                    shadow[i] <= s.in_data;
                                end
                            end
                            k <= k + 7'd1;
                        end
                    end
                end
                FULL: begin
                    if (!hold) begin
                        a_bus     <= launch_vec;
                        vec_valid <= 1'b1;
                        k         <= '0;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule
